// File: rtl/exc_entry_seq_pkg.sv
// Shared types and constants for the exception entry / RTE sequencer.
// Holds the FSM state encoding, SR/EXSR field positions and packing helpers.
package exc_entry_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EFLUSH,
    RFLUSH,
    ENTER,
    RESTORE,
    BRANCH
  } exc_state_e;

  localparam int SR_MD = 30;
  localparam int SR_RB = 29;
  localparam int SR_BL = 28;

  localparam int EXSR_CODE_LSB = 0;
  localparam int EXSR_CODE_MSB = 15;
  localparam int EXSR_SR_LSB   = 32;
  localparam int EXSR_SR_MSB   = 63;

  localparam logic [47:0] UV48_00 = 48'h0;
  localparam logic [63:0] UV64_00 = 64'h0;

  // SR comes out of reset in privileged mode.
  localparam logic [63:0] SR_RESET = 64'h0000_0000_4000_0000;

  function automatic logic [63:0] sr_enter(input logic [63:0] sr);
    logic [63:0] r;
    r        = sr;
    r[SR_MD] = 1'b1;
    r[SR_RB] = 1'b1;
    r[SR_BL] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] exsr_pack(input logic [31:0] sr_lo, input logic [15:0] code);
    logic [63:0] r;
    r                              = UV64_00;
    r[EXSR_SR_MSB:EXSR_SR_LSB]     = sr_lo;
    r[EXSR_CODE_MSB:EXSR_CODE_LSB] = code;
    return r;
  endfunction

endpackage

// File: rtl/exc_entry_seq_vec_calc.sv
// Vector address generator: VBR plus the shifted exception class, wrapping at 48 bits.
module exc_vec_calc #(
  parameter int VEC_SHIFT = 3
) (
  input  logic [47:0] vbr,
  input  logic [3:0]  code_hi,
  output logic [47:0] vec_addr
);

  logic [47:0] offset;

  always_comb begin
    offset   = {44'h0, code_hi} << VEC_SHIFT;
    vec_addr = vbr + offset;
  end

endmodule

// File: rtl/exc_entry_seq.sv
// Exception entry / RTE sequencer feeding the control-register file.
// Drains the pipeline, performs the SR/EXSR/SPC/SSP swap, then redirects fetch.
//
// state   | meaning
// IDLE    | pipeline next-state passes through to the CR file
// EFLUSH  | exception drain, excFlush asserted
// RFLUSH  | RTE drain, excFlush asserted
// ENTER   | exception CR swap and vector computation
// RESTORE | RTE CR swap, return to SPC
// BRANCH  | fetch redirect pending until brAck
module exc_entry_seq
  import exc_entry_seq_pkg::*;
#(
  parameter int FLUSH_CYC = 3,
  parameter int VEC_SHIFT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hold,
  input  logic        excValid,
  input  logic [15:0] excCode,
  input  logic [47:0] excPc,
  input  logic [63:0] excTea,
  input  logic        rteReq,
  input  logic [63:0] crSr,
  input  logic [63:0] crExsr,
  input  logic [63:0] crTea,
  input  logic [47:0] crSpc,
  input  logic [47:0] crSsp,
  input  logic [47:0] crVbr,
  input  logic [47:0] gprSp,
  input  logic [63:0] pipeSr,
  input  logic [63:0] pipeExsr,
  input  logic [63:0] pipeTea,
  input  logic [47:0] pipeSpc,
  input  logic [47:0] pipeSsp,
  input  logic [47:0] pipePc,
  input  logic [63:0] pipeLr,
  output logic [63:0] regInSr,
  output logic [63:0] regInExsr,
  output logic [63:0] regInTea,
  output logic [63:0] regInLr,
  output logic [47:0] regInSpc,
  output logic [47:0] regInSsp,
  output logic [47:0] regInPc,
  output logic        spWrValid,
  output logic [47:0] spWrVal,
  output logic        excFlush,
  output logic        brValid,
  output logic [47:0] brAddr,
  input  logic        brAck,
  output logic        excBusy,
  output logic        excDblFault
);

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYC - 1);

  exc_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] code_q, code_d;
  logic [47:0] pc_q, pc_d;
  logic [63:0] tea_q, tea_d;
  logic [63:0] lr_q, lr_d;

  logic [63:0] reg_in_sr_q, reg_in_sr_d;
  logic [63:0] reg_in_exsr_q, reg_in_exsr_d;
  logic [63:0] reg_in_tea_q, reg_in_tea_d;
  logic [63:0] reg_in_lr_q, reg_in_lr_d;
  logic [47:0] reg_in_spc_q, reg_in_spc_d;
  logic [47:0] reg_in_ssp_q, reg_in_ssp_d;
  logic [47:0] reg_in_pc_q, reg_in_pc_d;
  logic        sp_wr_valid_q, sp_wr_valid_d;
  logic [47:0] sp_wr_val_q, sp_wr_val_d;
  logic        exc_flush_q, exc_flush_d;
  logic        br_valid_q, br_valid_d;
  logic [47:0] br_addr_q, br_addr_d;
  logic        exc_busy_q, exc_busy_d;
  logic        dbl_fault_q, dbl_fault_d;

  logic [47:0] vec_addr;

  exc_vec_calc #(
    .VEC_SHIFT (VEC_SHIFT)
  ) u_vec_calc (
    .vbr      (crVbr),
    .code_hi  (code_q[15:12]),
    .vec_addr (vec_addr)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    code_d        = code_q;
    pc_d          = pc_q;
    tea_d         = tea_q;
    lr_d          = lr_q;
    // Outside IDLE and the swap cycles the CR file simply rewrites its own values.
    reg_in_sr_d   = crSr;
    reg_in_exsr_d = crExsr;
    reg_in_tea_d  = crTea;
    reg_in_spc_d  = crSpc;
    reg_in_ssp_d  = crSsp;
    reg_in_lr_d   = lr_q;
    reg_in_pc_d   = reg_in_pc_q;
    sp_wr_valid_d = 1'b0;
    sp_wr_val_d   = sp_wr_val_q;
    br_addr_d     = br_addr_q;
    dbl_fault_d   = dbl_fault_q;

    case (state_q)
      IDLE: begin
        reg_in_sr_d   = pipeSr;
        reg_in_exsr_d = pipeExsr;
        reg_in_tea_d  = pipeTea;
        reg_in_spc_d  = pipeSpc;
        reg_in_ssp_d  = pipeSsp;
        reg_in_pc_d   = pipePc;
        reg_in_lr_d   = pipeLr;
        if (excValid) begin
          state_d = EFLUSH;
          cnt_d   = CNT_LOAD;
          code_d  = excCode;
          pc_d    = excPc;
          tea_d   = excTea;
          lr_d    = pipeLr;
        end else if (rteReq) begin
          state_d = RFLUSH;
          cnt_d   = CNT_LOAD;
          lr_d    = pipeLr;
        end
      end
      EFLUSH, RFLUSH: begin
        if (cnt_q == 3'd0) begin
          state_d = (state_q == EFLUSH) ? ENTER : RESTORE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ENTER: begin
        reg_in_exsr_d = exsr_pack(crSr[31:0], code_q);
        reg_in_spc_d  = pc_q;
        reg_in_tea_d  = tea_q;
        reg_in_sr_d   = sr_enter(crSr);
        reg_in_ssp_d  = gprSp;
        sp_wr_valid_d = 1'b1;
        sp_wr_val_d   = crSsp;
        // Faulting with BL already set: go to the base vector, not the class offset.
        br_addr_d     = crSr[SR_BL] ? crVbr : vec_addr;
        reg_in_pc_d   = br_addr_d;
        dbl_fault_d   = dbl_fault_q | crSr[SR_BL];
        state_d       = BRANCH;
      end
      RESTORE: begin
        reg_in_sr_d   = {crSr[63:32], crExsr[EXSR_SR_MSB:EXSR_SR_LSB]};
        reg_in_ssp_d  = gprSp;
        sp_wr_valid_d = 1'b1;
        sp_wr_val_d   = crSsp;
        br_addr_d     = crSpc;
        reg_in_pc_d   = crSpc;
        state_d       = BRANCH;
      end
      BRANCH: begin
        if (br_valid_q && brAck) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    exc_flush_d = (state_d == EFLUSH) || (state_d == RFLUSH);
    br_valid_d  = (state_d == BRANCH);
    exc_busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      code_q        <= 16'h0;
      pc_q          <= UV48_00;
      tea_q         <= UV64_00;
      lr_q          <= UV64_00;
      reg_in_sr_q   <= SR_RESET;
      reg_in_exsr_q <= UV64_00;
      reg_in_tea_q  <= UV64_00;
      reg_in_lr_q   <= UV64_00;
      reg_in_spc_q  <= UV48_00;
      reg_in_ssp_q  <= UV48_00;
      reg_in_pc_q   <= UV48_00;
      sp_wr_valid_q <= 1'b0;
      sp_wr_val_q   <= UV48_00;
      exc_flush_q   <= 1'b0;
      br_valid_q    <= 1'b0;
      br_addr_q     <= UV48_00;
      exc_busy_q    <= 1'b0;
      dbl_fault_q   <= 1'b0;
    end else if (!hold) begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      code_q        <= code_d;
      pc_q          <= pc_d;
      tea_q         <= tea_d;
      lr_q          <= lr_d;
      reg_in_sr_q   <= reg_in_sr_d;
      reg_in_exsr_q <= reg_in_exsr_d;
      reg_in_tea_q  <= reg_in_tea_d;
      reg_in_lr_q   <= reg_in_lr_d;
      reg_in_spc_q  <= reg_in_spc_d;
      reg_in_ssp_q  <= reg_in_ssp_d;
      reg_in_pc_q   <= reg_in_pc_d;
      sp_wr_valid_q <= sp_wr_valid_d;
      sp_wr_val_q   <= sp_wr_val_d;
      exc_flush_q   <= exc_flush_d;
      br_valid_q    <= br_valid_d;
      br_addr_q     <= br_addr_d;
      exc_busy_q    <= exc_busy_d;
      dbl_fault_q   <= dbl_fault_d;
    end
  end

  assign regInSr     = reg_in_sr_q;
  assign regInExsr   = reg_in_exsr_q;
  assign regInTea    = reg_in_tea_q;
  assign regInLr     = reg_in_lr_q;
  assign regInSpc    = reg_in_spc_q;
  assign regInSsp    = reg_in_ssp_q;
  assign regInPc     = reg_in_pc_q;
  assign spWrValid   = sp_wr_valid_q;
  assign spWrVal     = sp_wr_val_q;
  assign excFlush    = exc_flush_q;
  assign brValid     = br_valid_q;
  assign brAddr      = br_addr_q;
  assign excBusy     = exc_busy_q;
  assign excDblFault = dbl_fault_q;

endmodule

// File: tb/tb_exc_entry_seq.sv
// Bench for exc_entry_seq: expected swap-cycle values are queued at request time
// and checked by a monitor whenever the DUT presents spWrValid.
module tb_exc_entry_seq;

  logic        clock = 1'b0;
  logic        reset, hold, excValid, rteReq, brAck;
  logic [15:0] excCode;
  logic [47:0] excPc;
  logic [63:0] excTea;
  logic [63:0] crSr, crExsr, crTea;
  logic [47:0] crSpc, crSsp, crVbr, gprSp;
  logic [63:0] pipeSr, pipeExsr, pipeTea, pipeLr;
  logic [47:0] pipeSpc, pipeSsp, pipePc;
  logic [63:0] regInSr, regInExsr, regInTea, regInLr;
  logic [47:0] regInSpc, regInSsp, regInPc;
  logic        spWrValid, excFlush, brValid, excBusy, excDblFault;
  logic [47:0] spWrVal, brAddr;

  always #5 clock = ~clock;

  exc_entry_seq dut (
    .clock(clock), .reset(reset), .hold(hold),
    .excValid(excValid), .excCode(excCode), .excPc(excPc), .excTea(excTea),
    .rteReq(rteReq),
    .crSr(crSr), .crExsr(crExsr), .crTea(crTea),
    .crSpc(crSpc), .crSsp(crSsp), .crVbr(crVbr), .gprSp(gprSp),
    .pipeSr(pipeSr), .pipeExsr(pipeExsr), .pipeTea(pipeTea),
    .pipeSpc(pipeSpc), .pipeSsp(pipeSsp), .pipePc(pipePc), .pipeLr(pipeLr),
    .regInSr(regInSr), .regInExsr(regInExsr), .regInTea(regInTea), .regInLr(regInLr),
    .regInSpc(regInSpc), .regInSsp(regInSsp), .regInPc(regInPc),
    .spWrValid(spWrValid), .spWrVal(spWrVal), .excFlush(excFlush),
    .brValid(brValid), .brAddr(brAddr), .brAck(brAck),
    .excBusy(excBusy), .excDblFault(excDblFault)
  );

  typedef struct {
    logic [63:0] sr, exsr, tea, lr;
    logic [47:0] spc, ssp, spv, br;
    logic        dbl;
    int          fl;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   fl_cnt = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: counts flush cycles and checks each swap cycle against the queue.
  always @(negedge clock) begin
    if (!reset) begin
      fl_cnt = 0;
    end else begin
      if (excFlush) fl_cnt++;
      if (spWrValid) begin
        if (sb.size() == 0) begin
          cmp("unexpected_swap", 64'(spWrValid), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          cmp("swap_sr",    regInSr,   mon_e.sr);
          cmp("swap_exsr",  regInExsr, mon_e.exsr);
          cmp("swap_tea",   regInTea,  mon_e.tea);
          cmp("swap_lr",    regInLr,   mon_e.lr);
          cmp("swap_spc",   64'(regInSpc), 64'(mon_e.spc));
          cmp("swap_ssp",   64'(regInSsp), 64'(mon_e.ssp));
          cmp("swap_spval", 64'(spWrVal),  64'(mon_e.spv));
          cmp("swap_braddr", 64'(brAddr),  64'(mon_e.br));
          cmp("swap_pc",    64'(regInPc),  64'(mon_e.br));
          cmp("swap_brvalid", 64'(brValid), 64'd1);
          cmp("swap_dbl",   64'(excDblFault), 64'(mon_e.dbl));
          cmp("flush_cycles", 64'(fl_cnt), 64'(mon_e.fl));
        end
        fl_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] sr, input logic [63:0] exsr, input logic [63:0] tea,
                          input logic [47:0] spc, input logic [47:0] br, input logic dbl,
                          input int fl);
    exp_t t;
    t.sr = sr; t.exsr = exsr; t.tea = tea; t.lr = pipeLr;
    t.spc = spc; t.ssp = gprSp; t.spv = crSsp; t.br = br;
    t.dbl = dbl; t.fl = fl;
    sb.push_back(t);
  endtask

  // Pulse the request, then scramble request-time inputs to prove they were latched.
  task automatic issue(input logic ex, input logic rte);
    excValid = ex;
    rteReq   = rte;
    step();
    excValid = 1'b0;
    rteReq   = 1'b0;
    excCode  = 16'hFFFF;
    excPc    = 48'hFFFF_FFFF_FFFF;
    excTea   = 64'hFFFF_FFFF_FFFF_FFFF;
    pipeLr   = 64'h0BAD_0BAD_0BAD_0BAD;
  endtask

  task automatic finish_seq(input logic ack);
    int n = 0;
    while (brValid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    cmp("br_valid_seen", 64'(brValid), 64'd1);
    if (ack) begin
      brAck = 1'b1;
      step();
      brAck = 1'b0;
      cmp("idle_after_ack", 64'(excBusy), 64'd0);
      cmp("br_drop", 64'(brValid), 64'd0);
      pipeLr = 64'h1111_0000_2222_0000;
      step();
    end
  endtask

  initial begin
    reset = 1'b0; hold = 1'b0; excValid = 1'b0; rteReq = 1'b0; brAck = 1'b0;
    excCode = 16'h0; excPc = 48'h0; excTea = 64'h0;
    crSr = 64'h0; crExsr = 64'h0000_1234_0000_0000; crTea = 64'h7EA0;
    crSpc = 48'h5678; crSsp = 48'hF000; crVbr = 48'h0000_0100_0000; gprSp = 48'h8000;
    pipeSr = 64'h1111_2222_3333_4444; pipeExsr = 64'h5555_6666_7777_8888;
    pipeTea = 64'h9999_AAAA_BBBB_CCCC; pipeLr = 64'h1111_0000_2222_0000;
    pipeSpc = 48'h0000_AAAA_0001; pipeSsp = 48'h0000_BBBB_0002; pipePc = 48'h0000_0000_4000;
    step();
    step();
    cmp("rst_sr", regInSr, 64'h0000_0000_4000_0000);
    cmp("rst_exsr", regInExsr, 64'h0);
    cmp("rst_pc", 64'(regInPc), 64'h0);
    cmp("rst_busy", 64'(excBusy), 64'd0);
    cmp("rst_brvalid", 64'(brValid), 64'd0);
    cmp("rst_flush", 64'(excFlush), 64'd0);
    cmp("rst_dbl", 64'(excDblFault), 64'd0);

    reset = 1'b1;
    step();
    cmp("idle_sr", regInSr, pipeSr);
    cmp("idle_pc", 64'(regInPc), 64'(pipePc));
    cmp("idle_lr", regInLr, pipeLr);
    cmp("idle_ssp", 64'(regInSsp), 64'(pipeSsp));

    // Exception entry
    excCode = 16'hA001; excPc = 48'h1234; excTea = 64'hDEAD_BEEF;
    push_exp(64'h0000_0000_7000_0000, 64'h0000_0000_0000_A001, 64'hDEAD_BEEF,
             48'h1234, 48'h0000_0100_0050, 1'b0, 3);
    issue(1'b1, 1'b0);
    finish_seq(1'b1);

    // RTE
    crSr = 64'hAAAA_0000_7000_0000;
    push_exp(64'hAAAA_0000_0000_1234, crExsr, crTea, crSpc, 48'h5678, 1'b0, 3);
    issue(1'b0, 1'b1);
    finish_seq(1'b1);

    // Simultaneous request: exception wins
    crSr = 64'h1;
    excCode = 16'h3005; excPc = 48'hABC; excTea = 64'h1;
    push_exp(64'h0000_0000_7000_0001, 64'h0000_0001_0000_3005, 64'h1,
             48'hABC, 48'h0000_0100_0018, 1'b0, 3);
    issue(1'b1, 1'b1);
    finish_seq(1'b1);
    cmp("rte_dropped", 64'(excBusy), 64'd0);

    // Hold during EFLUSH
    crSr = 64'h0;
    excCode = 16'hA001; excPc = 48'h1234; excTea = 64'hDEAD_BEEF;
    push_exp(64'h0000_0000_7000_0000, 64'h0000_0000_0000_A001, 64'hDEAD_BEEF,
             48'h1234, 48'h0000_0100_0050, 1'b0, 8);
    issue(1'b1, 1'b0);
    step();
    hold = 1'b1;
    repeat (5) step();
    cmp("hold_flush", 64'(excFlush), 64'd1);
    cmp("hold_busy", 64'(excBusy), 64'd1);
    hold = 1'b0;
    finish_seq(1'b1);

    // Double fault
    crSr = 64'h0000_0000_1000_0000; crVbr = 48'h0000_0200_0000;
    excCode = 16'h2002; excPc = 48'h2222; excTea = 64'h22;
    push_exp(64'h0000_0000_7000_0000, 64'h1000_0000_0000_2002, 64'h22,
             48'h2222, 48'h0000_0200_0000, 1'b1, 3);
    issue(1'b1, 1'b0);
    finish_seq(1'b1);

    // Vector wrap; double-fault flag stays set
    crSr = 64'h0; crVbr = 48'hFFFF_FFFF_FFF0;
    excCode = 16'hF000; excPc = 48'h6666; excTea = 64'h66;
    push_exp(64'h0000_0000_7000_0000, 64'h0000_0000_0000_F000, 64'h66,
             48'h6666, 48'h0000_0000_0068, 1'b1, 3);
    issue(1'b1, 1'b0);
    finish_seq(1'b1);
    cmp("dbl_sticky", 64'(excDblFault), 64'd1);

    // Reset while BRANCH waits for brAck
    crVbr = 48'h0000_0100_0000;
    excCode = 16'h1001; excPc = 48'h7777; excTea = 64'h77;
    push_exp(64'h0000_0000_7000_0000, 64'h0000_0000_0000_1001, 64'h77,
             48'h7777, 48'h0000_0100_0008, 1'b1, 3);
    issue(1'b1, 1'b0);
    finish_seq(1'b0);
    step();
    step();
    cmp("branch_pending", 64'(brValid), 64'd1);
    reset = 1'b0;
    step();
    cmp("midrst_busy", 64'(excBusy), 64'd0);
    cmp("midrst_brvalid", 64'(brValid), 64'd0);
    cmp("midrst_sr", regInSr, 64'h0000_0000_4000_0000);
    cmp("midrst_dbl", 64'(excDblFault), 64'd0);
    reset = 1'b1;
    step();
    step();
    cmp("post_rst_busy", 64'(excBusy), 64'd0);
    cmp("post_rst_sr", regInSr, pipeSr);
    cmp("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
